xup_prbs_checker: RTL and testbench
===================================

# xup_prbs_checker

- Serial receiving end of the library's XNOR-feedback LFSR (PRBS) generator.
- Self-synchronises to an incoming pseudo-random bit stream and declares lock.
- Once locked, flywheels its own prediction and counts bit errors.
- Used after a serial link or channel model in lab designs to measure bit-error rate.

## Interface

- SIZE, 7, LFSR length in bits (≥3).
- TAP_A, 7, first feedback tap (1-based, ≤SIZE).
- TAP_B, 6, second feedback tap (1-based, ≤SIZE, ≠TAP_A).
- LOCK_COUNT, 16, consecutive matching beats required to declare lock.
- LOSS_COUNT, 4, consecutive mismatching beats while locked that force loss of lock.
- ERR_WIDTH, 16, width of the error counter.
- clk, input, 1, rising-edge clock.
- resetn, input, 1, reset, synchronous and active-low.
- din, input, 1, received serial bit.
- din_valid, input, 1, din is sampled only when high.
- err_clr, input, 1, synchronous clear of err_count.
- locked, output, 1, high while the checker is in LOCKED.
- bit_err, output, 1, one-cycle pulse for each mismatching beat while LOCKED.
- err_count, output, ERR_WIDTH, saturating count of mismatches while LOCKED.

## Operation

- Shift register sr[SIZE-1:0] shifts left: sr <= {sr[SIZE-2:0], in_bit}.
- Predicted bit: p = ~(sr[TAP_A-1] ^ sr[TAP_B-1]), i.e. XNOR feedback matching the generator.
- A "beat" is a cycle with din_valid=1; all state and counters are frozen on other cycles.
- The all-ones sr value is the XNOR lock-up state and is never accepted as valid.
- State machine:
  - HUNT: in_bit=din; fill counter increments per beat; after SIZE beats go to VERIFY with match counter=0.
  - VERIFY: in_bit=din; din==p and sr not all-ones increments the match counter; reaching LOCK_COUNT goes to LOCKED. Any mismatch, or sr all-ones, returns to HUNT with the fill counter cleared.
  - LOCKED: in_bit=p (flywheel, so channel errors do not corrupt the prediction). din!=p pulses bit_err and increments err_count (saturating at all-ones). LOSS_COUNT consecutive mismatches return to HUNT; any match clears the consecutive-miss counter.
- Beats in HUNT/VERIFY never touch err_count or bit_err.
- err_clr zeroes err_count the next cycle. If err_clr and a counted error occur in the same cycle, clear wins and the result is 0.

## Timing

- Reset (resetn=0 at a clock edge): state=HUNT, sr=0, all internal counters=0, locked=0, bit_err=0, err_count=0.
- Reset mid-operation behaves identically and takes effect at that edge, regardless of din_valid.
- All outputs are registered and reflect the beat sampled at the previous edge.
- Clean stream from reset: locked rises the cycle after beat number SIZE+LOCK_COUNT (the 23rd beat with defaults).
- bit_err is high for exactly one cycle per erroring beat and is never high when locked=0, except on the final mismatch that causes loss of lock.
- locked falls the cycle after the LOSS_COUNT-th consecutive mismatch. That beat still pulses bit_err and counts.
- Throughput is one bit per clock; din_valid may be held high continuously.

## Test plan

- Clean lock: after reset, feed a continuous generator stream (seed 7'h00, taps 7/6). Require locked=0 through beat 22, locked=1 after beat 23, err_count=0 after 200 further beats.
- Single errors: once locked, invert beats 50, 51 and 120. Require three single-cycle bit_err pulses, err_count=3, locked stays 1, and no error propagation on subsequent beats.
- Loss of lock: once locked, invert 4 consecutive beats. Require err_count=4 and locked=0 on the cycle after the 4th beat. Then, with a clean stream, require relock after 23 further beats.
- Lock-up rejection: hold din=1 with din_valid=1 for 100 beats. Require locked never asserts.
- Gaps and clear: lock with din_valid toggling 1/0 and verify the same beat-based latency. Inject 2 errors, then assert err_clr in the same cycle as a third error. Require err_count=0.
- Saturation and reset: with ERR_WIDTH=3, inject 10 isolated errors. Require err_count=7. Then assert resetn=0 for one cycle mid-stream. Require locked=0, err_count=0, bit_err=0 next cycle.

Source files
------------

// File: rtl/xup_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module      : xup_prbs_checker
// Description : Serial PRBS checker for the XNOR-feedback LFSR generator.
//               Hunts for SIZE bits of the incoming stream, verifies that
//               LOCK_COUNT further bits follow the LFSR recurrence, then
//               locks and flywheels its own prediction while counting bit
//               errors. LOSS_COUNT consecutive errors drop lock.
// Ports       : clk        - rising-edge clock
//               resetn     - synchronous active-low reset
//               din        - received serial bit
//               din_valid  - qualifies din; all state frozen when low
//               err_clr    - synchronous clear of err_count
//               locked     - high while in the LOCKED state
//               bit_err    - one-cycle pulse per erroring beat while locked
//               err_count  - saturating error count
// Revision    : 1.0 - initial release
// ============================================================================
module xup_prbs_checker #(
  parameter int SIZE       = 7,
  parameter int TAP_A      = 7,
  parameter int TAP_B      = 6,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 bit_err,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam int C_FILL_W  = $clog2(SIZE + 1);
  localparam int C_MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int C_MISS_W  = $clog2(LOSS_COUNT + 1);

  // Terminal values are one less than the target: the transition fires on
  // the beat that would bring the counter up to the target.
  localparam logic [C_FILL_W-1:0]  C_FILL_LAST  = C_FILL_W'(SIZE - 1);
  localparam logic [C_MATCH_W-1:0] C_MATCH_LAST = C_MATCH_W'(LOCK_COUNT - 1);
  localparam logic [C_MISS_W-1:0]  C_MISS_LAST  = C_MISS_W'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                 state_q,     state_d;
  logic [SIZE-1:0]        sr_q,        sr_d;
  logic [C_FILL_W-1:0]    fill_q,      fill_d;
  logic [C_MATCH_W-1:0]   match_q,     match_d;
  logic [C_MISS_W-1:0]    miss_q,      miss_d;
  logic                   bit_err_q,   bit_err_d;
  logic [ERR_WIDTH-1:0]   err_count_q, err_count_d;

  logic w_pred;
  logic w_all_ones;

  // Next bit the generator would emit given the last SIZE received bits.
  assign w_pred     = ~(sr_q[TAP_A-1] ^ sr_q[TAP_B-1]);
  // All-ones is the XNOR lock-up state; a stream stuck there is not a PRBS.
  assign w_all_ones = &sr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      bit_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      bit_err_q   <= bit_err_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    bit_err_d   = 1'b0;
    err_count_d = err_count_q;

    if (din_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          sr_d = {sr_q[SIZE-2:0], din};
          if (fill_q == C_FILL_LAST) begin
            state_d = ST_VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + C_FILL_W'(1);
          end
        end

        ST_VERIFY: begin
          sr_d = {sr_q[SIZE-2:0], din};
          if ((din == w_pred) && !w_all_ones) begin
            if (match_q == C_MATCH_LAST) begin
              state_d = ST_LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + C_MATCH_W'(1);
            end
          end else begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: the register follows the prediction, so a corrupted
          // received bit cannot poison the following predictions.
          sr_d = {sr_q[SIZE-2:0], w_pred};
          if (din != w_pred) begin
            bit_err_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_WIDTH'(1);
            end
            if (miss_q == C_MISS_LAST) begin
              state_d = ST_HUNT;
              fill_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + C_MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end

        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase
    end

    // Clear has priority over an error counted in the same cycle.
    if (err_clr) begin
      err_count_d = '0;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign bit_err   = bit_err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_xup_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_xup_prbs_checker
// Description : Self-checking bench for xup_prbs_checker. Two instances share
//               stimulus: one with the default 16-bit error counter, one with
//               a 3-bit counter for saturation. A behavioural model built on
//               a history queue predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xup_prbs_checker;

  localparam int SIZE       = 7;
  localparam int TAP_A      = 7;
  localparam int TAP_B      = 6;
  localparam int LOCK_COUNT = 16;
  localparam int LOSS_COUNT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        locked, bit_err;
  logic [15:0] err_count;
  logic        locked_s, bit_err_s;
  logic [2:0]  err_count_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xup_prbs_checker #(
    .SIZE(SIZE), .TAP_A(TAP_A), .TAP_B(TAP_B),
    .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_WIDTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .err_clr(err_clr), .locked(locked), .bit_err(bit_err),
    .err_count(err_count)
  );

  xup_prbs_checker #(
    .SIZE(SIZE), .TAP_A(TAP_A), .TAP_B(TAP_B),
    .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_WIDTH(3)
  ) dut_s (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .err_clr(err_clr), .locked(locked_s), .bit_err(bit_err_s),
    .err_count(err_count_s)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- generator (seed all-zero) ----------------
  bit g_hist[$];

  task automatic gen_reset();
    g_hist = {};
    for (int i = 0; i < SIZE; i++) g_hist.push_back(1'b0);
  endtask

  task automatic gen_bit(output bit b);
    b = ~(g_hist[SIZE-TAP_A] ^ g_hist[SIZE-TAP_B]);
    g_hist.push_back(b);
    void'(g_hist.pop_front());
  endtask

  // ---------------- reference model ----------------
  // m_hist holds the last SIZE register bits, oldest first.
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
  int m_mode, m_fill, m_match, m_miss, m_cnt;
  bit m_berr;
  bit m_hist[$];

  task automatic model_reset();
    m_mode = M_HUNT; m_fill = 0; m_match = 0; m_miss = 0; m_cnt = 0;
    m_berr = 1'b0;
    m_hist = {};
    for (int i = 0; i < SIZE; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_edge(input bit v, input bit d, input bit clr);
    bit p, ones;
    m_berr = 1'b0;
    if (v) begin
      p = ~(m_hist[SIZE-TAP_A] ^ m_hist[SIZE-TAP_B]);
      ones = 1'b1;
      for (int i = 0; i < SIZE; i++) if (!m_hist[i]) ones = 1'b0;
      if (m_mode == M_HUNT) begin
        m_hist.push_back(d);
        m_fill++;
        if (m_fill == SIZE) begin m_mode = M_VERIFY; m_match = 0; end
      end else if (m_mode == M_VERIFY) begin
        m_hist.push_back(d);
        if (d == p && !ones) begin
          m_match++;
          if (m_match == LOCK_COUNT) begin m_mode = M_LOCKED; m_miss = 0; end
        end else begin
          m_mode = M_HUNT; m_fill = 0;
        end
      end else begin
        m_hist.push_back(p);
        if (d != p) begin
          m_berr = 1'b1;
          m_cnt++;
          m_miss++;
          if (m_miss == LOSS_COUNT) begin m_mode = M_HUNT; m_fill = 0; end
        end else begin
          m_miss = 0;
        end
      end
      void'(m_hist.pop_front());
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic compare_all(input string tag);
    int e16, e3;
    e16 = (m_cnt > 65535) ? 65535 : m_cnt;
    e3  = (m_cnt > 7) ? 7 : m_cnt;
    check_val({tag, "_locked"},  32'(locked),      32'(m_mode == M_LOCKED));
    check_val({tag, "_bit_err"}, 32'(bit_err),     32'(m_berr));
    check_val({tag, "_count"},   32'(err_count),   32'(e16));
    check_val({tag, "_locked3"}, 32'(locked_s),    32'(m_mode == M_LOCKED));
    check_val({tag, "_count3"},  32'(err_count_s), 32'(e3));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input bit d, input bit clr);
    din = d; din_valid = v; err_clr = clr;
    @(posedge clk);
    model_edge(v, d, clr);
    #1;
    compare_all("cyc");
  endtask

  task automatic reset_cycle(input bit v, input bit d);
    resetn = 1'b0; din = d; din_valid = v; err_clr = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all("rst");
    resetn = 1'b1;
  endtask

  task automatic beat(input bit inj, input bit clr);
    bit b;
    gen_bit(b);
    step(1'b1, b ^ inj, clr);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  int  pulses;
  int  beats;
  bit  seen;

  initial begin
    model_reset();
    gen_reset();

    // Reset state, with valid high so reset is shown to dominate.
    reset_cycle(1'b1, 1'b1);
    reset_cycle(1'b1, 1'b0);
    check_val("reset_locked", 32'(locked), 32'd0);
    check_val("reset_count",  32'(err_count), 32'd0);

    // Clean lock: locked only after beat SIZE+LOCK_COUNT.
    for (int b = 1; b <= SIZE + LOCK_COUNT; b++) begin
      beat(1'b0, 1'b0);
      check_val("lock_latency", 32'(locked), 32'(b >= 23));
    end
    repeat (200) beat(1'b0, 1'b0);
    check_val("clean_count", 32'(err_count), 32'd0);
    check_val("clean_locked", 32'(locked), 32'd1);

    // Single errors on beats 50, 51 and 120.
    pulses = 0;
    for (int k = 1; k <= 150; k++) begin
      beat(k == 50 || k == 51 || k == 120, 1'b0);
      if (bit_err) pulses++;
    end
    check_val("single_pulses", 32'(pulses), 32'd3);
    check_val("single_count",  32'(err_count), 32'd3);
    check_val("single_locked", 32'(locked), 32'd1);

    // Loss of lock after four consecutive errors.
    step(1'b0, 1'b0, 1'b1);
    check_val("clr_idle", 32'(err_count), 32'd0);
    for (int k = 1; k <= LOSS_COUNT; k++) begin
      beat(1'b1, 1'b0);
      check_val("loss_locked", 32'(locked), 32'(k < 4));
    end
    check_val("loss_count", 32'(err_count), 32'd4);
    check_val("loss_biterr", 32'(bit_err), 32'd1);
    for (int k = 1; k <= SIZE + LOCK_COUNT; k++) begin
      beat(1'b0, 1'b0);
      check_val("relock", 32'(locked), 32'(k >= 23));
    end
    check_val("relock_count", 32'(err_count), 32'd4);

    // Lock-up rejection: constant ones never locks.
    reset_cycle(1'b0, 1'b0);
    seen = 1'b0;
    repeat (100) begin
      step(1'b1, 1'b1, 1'b0);
      if (locked || bit_err) seen = 1'b1;
    end
    check_val("lockup_never", 32'(seen), 32'd0);

    // Gaps: alternate valid, latency still counted in beats.
    reset_cycle(1'b0, 1'b0);
    gen_reset();
    beats = 0;
    while (beats < SIZE + LOCK_COUNT) begin
      beat(1'b0, 1'b0);
      beats++;
      check_val("gap_latency", 32'(locked), 32'(beats >= 23));
      idle();
      check_val("gap_hold", 32'(locked), 32'(beats >= 23));
    end
    beat(1'b1, 1'b0); idle(); repeat (3) beat(1'b0, 1'b0);
    beat(1'b1, 1'b0); idle(); repeat (3) beat(1'b0, 1'b0);
    check_val("gap_two_errs", 32'(err_count), 32'd2);
    beat(1'b1, 1'b1);
    check_val("clr_wins", 32'(err_count), 32'd0);
    check_val("clr_pulse", 32'(bit_err), 32'd1);

    // Saturation in the 3-bit instance.
    for (int k = 0; k < 10; k++) begin
      beat(1'b1, 1'b0);
      repeat (5) beat(1'b0, 1'b0);
    end
    check_val("sat_count3",  32'(err_count_s), 32'd7);
    check_val("sat_count16", 32'(err_count), 32'd10);
    check_val("sat_locked",  32'(locked), 32'd1);

    // Mid-stream reset, during an erroring beat.
    gen_bit(seen);
    reset_cycle(1'b1, ~seen);
    check_val("mid_reset_locked", 32'(locked), 32'd0);
    check_val("mid_reset_biterr", 32'(bit_err), 32'd0);
    check_val("mid_reset_count3", 32'(err_count_s), 32'd0);

    // Randomised traffic: gaps, sparse errors, clears and rare resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        beat(($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
